up_reg_initiator: RTL and testbench
===================================

// Module: up_reg_initiator
// PURPOSE
//  Initiator (master) side of the up_* register bus. Converts single-beat commands (valid/ready)
//  into up_wreq/up_rreq transactions toward a regmap responder, waits for up_wack/up_rack,
//  and returns read data or a timeout error. Used for on-chip register access by sequencer or test logic.
// PARAMETERS
//  ADDR_WIDTH     14     up_waddr/up_raddr width
//  DATA_WIDTH     32     data width
//  TIMEOUT_CYCLES 255    cycles in WAIT without ack before error; must be >=1; counter is $clog2(TIMEOUT_CYCLES+1) bits
//  ADDR_LIMIT     14'h40 first illegal address (used only with UP_REG_INIT_ADDR_CHECK_EN)
// PORTS
//  up_clk     in   1   clock
//  up_rstn    in   1   synchronous reset, active low
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when valid&ready
//  cmd_write  in   1   1=write, 0=read
//  cmd_addr   in   AW  register address
//  cmd_wdata  in   DW  write data
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   response consumed when valid&ready
//  rsp_rdata  out  DW  read data (0 for writes and errors)
//  rsp_error  out  1   1=timeout or address rejected
//  up_wreq    out  1   write request pulse
//  up_waddr   out  AW  write address
//  up_wdata   out  DW  write data
//  up_wack    in   1   write acknowledge
//  up_rreq    out  1   read request pulse
//  up_raddr   out  AW  read address
//  up_rdata   in   DW  read data, sampled on up_rack
//  up_rack    in   1   read acknowledge
// BEHAVIOUR
//  Reset (up_rstn=0 at edge): state=IDLE; all outputs 0 except cmd_ready=1 (registered, set on first cycle out of reset).
//  FSM IDLE->REQ->WAIT->RESP->IDLE. cmd_ready=1 only in IDLE; cmd fields latched on accept.
//  REQ: exactly one cycle; up_wreq or up_rreq=1 per latched cmd_write. Timeout counter cleared.
//  Address and wdata held stable from REQ until leaving WAIT; driven 0 in IDLE and RESP.
//  WAIT: matching ack (up_wack for write, up_rack for read) -> RESP, rsp_error=0, rsp_rdata=up_rdata (read) or 0.
//  Non-matching ack in WAIT is ignored. Any ack in IDLE, REQ or RESP is ignored.
//  Timeout: counter increments each WAIT cycle; reaching TIMEOUT_CYCLES -> RESP with rsp_error=1, rsp_rdata=0.
//  Matching ack in the same cycle the counter reaches TIMEOUT_CYCLES: the ack wins (no error).
//  RESP: rsp_valid=1; rdata/error held until rsp_ready; transition to IDLE on valid&ready.
//  Latency: with a 1-cycle-ack responder: accept@T, req@T+1, ack@T+2, rsp_valid@T+3. Throughput: 1 cmd per 4 cycles min.
//  up_rstn low mid-transaction: outstanding transaction dropped, no response issued, late ack ignored.
//  Only one transaction outstanding at any time; up_wreq and up_rreq are never both 1.
// CONFIGURATION
//  `UP_REG_INIT_ADDR_CHECK_EN defined: command with cmd_addr>=ADDR_LIMIT is accepted, no up_*req is issued,
//   FSM goes IDLE->RESP directly with rsp_error=1, rsp_rdata=0 (rsp_valid at T+1).
//  Undefined: no address check; ADDR_LIMIT unused; every command is issued on the bus.
// STRUCTURE
//  Package up_reg_init_pkg: typedef enum logic [1:0] {IDLE,REQ,WAIT,RESP} up_init_state_t;
//   localparam default TIMEOUT_CYCLES; response struct {logic error; logic [31:0] rdata}.
//  Single module; no sub-module. Timeout counter and FSM are inline.
// TESTING
//  Write 0x4/0xDEADBEEF, responder acks 1 cycle later -> up_wreq pulse 1 cycle, rsp_valid@T+3, error=0, rdata=0.
//  Read 0x2 after scratch write 0x12345678 -> up_rreq pulse 1 cycle, rsp_rdata=0x12345678, error=0.
//  No responder ack, TIMEOUT_CYCLES=8 -> rsp_error=1 after 8 WAIT cycles; later stray up_wack ignored.
//  rsp_ready held 0 for 10 cycles -> rsp_valid/rdata stable, cmd_ready=0; next cmd accepted after handshake.
//  Ack on exact timeout cycle -> error=0. up_rstn pulsed during WAIT -> no response, outputs at reset values.
//  With UP_REG_INIT_ADDR_CHECK_EN, ADDR_LIMIT=0x40: read 0x40 -> no up_rreq, rsp_error=1 at T+1; read 0x3F -> issued.

Source files
------------

// File: rtl/up_reg_initiator_pkg.sv
// Shared types and defaults for the up_* register bus initiator.
package up_reg_init_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } up_init_state_t;

    localparam int unsigned UP_INIT_TIMEOUT_DEFAULT = 255;
    localparam int unsigned UP_INIT_AW_DEFAULT      = 14;
    localparam int unsigned UP_INIT_DW_DEFAULT      = 32;

    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } up_init_rsp_t;

endpackage

// File: rtl/up_reg_initiator_if.sv
// Command, response and up_* bus signals of the register initiator.
// master = initiator view, slave = command source / regmap responder view.
interface up_reg_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;

    logic                  up_wreq;
    logic [ADDR_WIDTH-1:0] up_waddr;
    logic [DATA_WIDTH-1:0] up_wdata;
    logic                  up_wack;
    logic                  up_rreq;
    logic [ADDR_WIDTH-1:0] up_raddr;
    logic [DATA_WIDTH-1:0] up_rdata;
    logic                  up_rack;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output up_wreq, up_waddr, up_wdata,
        input  up_wack,
        output up_rreq, up_raddr,
        input  up_rdata, up_rack
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  up_wreq, up_waddr, up_wdata,
        output up_wack,
        input  up_rreq, up_raddr,
        output up_rdata, up_rack
    );

endinterface

// File: rtl/up_reg_initiator.sv
// Single-outstanding up_* bus initiator: command -> wreq/rreq -> ack or timeout -> response.
// Optional `UP_REG_INIT_ADDR_CHECK_EN rejects cmd_addr >= ADDR_LIMIT without touching the bus.
module up_reg_initiator
    import up_reg_init_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = UP_INIT_AW_DEFAULT,
    parameter int unsigned           DATA_WIDTH     = UP_INIT_DW_DEFAULT,
    parameter int unsigned           TIMEOUT_CYCLES = UP_INIT_TIMEOUT_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = ADDR_WIDTH'('h40)
) (
    input  logic              up_clk,
    input  logic              up_rstn,
    up_reg_initiator_if.master bus
);

    localparam int unsigned           CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    if (TIMEOUT_CYCLES == 0) begin : g_chk_timeout
        $error("up_reg_initiator: TIMEOUT_CYCLES must be >= 1");
    end
    if (ADDR_LIMIT == '0) begin : g_chk_limit
        $error("up_reg_initiator: ADDR_LIMIT must be nonzero");
    end

    up_init_state_t        r_state;
    up_init_state_t        w_state_nxt;
    logic                  r_cmd_ready;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  r_rsp_error;
    logic                  w_rsp_error_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_accept;
    logic                  w_ack_match;
    logic                  w_timeout;
    logic                  w_addr_bad;
    logic                  w_busy;

`ifdef UP_REG_INIT_ADDR_CHECK_EN
    assign w_addr_bad = (bus.cmd_addr >= ADDR_LIMIT);
`else
    assign w_addr_bad = 1'b0;
`endif

    // r_cmd_ready is only ever set while the next state is IDLE, so it doubles as the IDLE qualifier.
    assign w_accept    = bus.cmd_valid & r_cmd_ready;
    assign w_ack_match = r_write ? bus.up_wack : bus.up_rack;
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_timeout   = (w_cnt_inc == CNT_MAX);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_error_nxt = r_rsp_error;
        w_rsp_rdata_nxt = r_rsp_rdata;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_addr_bad) begin
                        w_state_nxt     = RESP;
                        w_rsp_error_nxt = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A matching ack is checked first so it wins over a coincident timeout.
                if (w_ack_match) begin
                    w_state_nxt     = RESP;
                    w_rsp_error_nxt = 1'b0;
                    w_rsp_rdata_nxt = r_write ? '0 : bus.up_rdata;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_timeout) begin
                        w_state_nxt     = RESP;
                        w_rsp_error_nxt = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_error_nxt = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_cnt       <= w_cnt_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            if (w_accept) begin
                r_write <= bus.cmd_write;
                r_addr  <= bus.cmd_addr;
                r_wdata <= bus.cmd_wdata;
            end
        end
    end

    assign w_busy = (r_state == REQ) || (r_state == WAIT);

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_error = r_rsp_error;
    assign bus.rsp_rdata = r_rsp_rdata;

    assign bus.up_wreq  = (r_state == REQ) & r_write;
    assign bus.up_rreq  = (r_state == REQ) & ~r_write;
    assign bus.up_waddr = (w_busy & r_write)  ? r_addr  : '0;
    assign bus.up_wdata = (w_busy & r_write)  ? r_wdata : '0;
    assign bus.up_raddr = (w_busy & ~r_write) ? r_addr  : '0;

endmodule

// File: tb/tb_up_reg_initiator.sv
// Randomized bench for up_reg_initiator: scripted responder plus a memory/latency reference model.
`timescale 1ns/1ps
module tb_up_reg_initiator;
    import up_reg_init_pkg::*;

    localparam int unsigned     AW    = 14;
    localparam int unsigned     DW    = 32;
    localparam int              TO    = 8;
    localparam logic [AW-1:0]   LIMIT = 14'h40;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    up_reg_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_bus ();

    up_reg_initiator #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .ADDR_LIMIT    (LIMIT)
    ) u_dut (
        .up_clk (clk),
        .up_rstn(rstn),
        .bus    (u_bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [64];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        u_bus.cmd_valid = 1'b0;
        u_bus.cmd_write = 1'b0;
        u_bus.cmd_addr  = '0;
        u_bus.cmd_wdata = '0;
        u_bus.rsp_ready = 1'b0;
        u_bus.up_wack   = 1'b0;
        u_bus.up_rack   = 1'b0;
        u_bus.up_rdata  = $urandom;
    endtask

    task automatic drive_garbage_cmd();
        u_bus.cmd_valid = 1'($urandom_range(0, 1));
        u_bus.cmd_write = 1'($urandom_range(0, 1));
        u_bus.cmd_addr  = AW'($urandom);
        u_bus.cmd_wdata = $urandom;
    endtask

    // Responder acks d cycles after the request cycle; d outside 1..TO yields a timeout.
    function automatic up_init_rsp_t model_rsp(input bit wr, input logic [5:0] idx, input int d, input bit rej);
        up_init_rsp_t r;
        if (rej || d < 1 || d > TO) begin
            r.error = 1'b1;
            r.rdata = '0;
        end else begin
            r.error = 1'b0;
            r.rdata = wr ? 32'h0 : mem[idx];
        end
        return r;
    endfunction

    task automatic do_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int d, input int hold);
        bit           rej;
        up_init_rsp_t exp;
        int           lat;
        logic [59:0]  exp_bus;
        logic [5:0]   idx;
        idx = a[5:0];
        rej = 1'b0;
`ifdef UP_REG_INIT_ADDR_CHECK_EN
        rej = (a >= LIMIT);
`endif
        exp     = model_rsp(wr, idx, d, rej);
        lat     = rej ? 1 : ((d >= 1 && d <= TO) ? 2 + d : 2 + TO);
        exp_bus = wr ? {a, 14'h0, wd} : {14'h0, a, 32'h0};

        check_val("idle_hs", {u_bus.cmd_ready, u_bus.rsp_valid, u_bus.up_wreq, u_bus.up_rreq}, 4'b1000);
        u_bus.cmd_valid = 1'b1;
        u_bus.cmd_write = wr;
        u_bus.cmd_addr  = a;
        u_bus.cmd_wdata = wd;
        tick();

        for (int c = 1; c < lat; c++) begin
            check_val("busy_hs", {u_bus.cmd_ready, u_bus.rsp_valid, u_bus.up_wreq, u_bus.up_rreq},
                      {2'b00, (c == 1) && wr, (c == 1) && !wr});
            check_val("busy_bus", {u_bus.up_waddr, u_bus.up_raddr, u_bus.up_wdata}, exp_bus);
            drive_garbage_cmd();
            u_bus.up_rdata = $urandom;
            u_bus.up_wack  = 1'b0;
            u_bus.up_rack  = 1'b0;
            if (c == 1 + d) begin
                if (wr) u_bus.up_wack = 1'b1;
                else begin
                    u_bus.up_rack  = 1'b1;
                    u_bus.up_rdata = mem[idx];
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if (wr) u_bus.up_rack = 1'b1;
                else    u_bus.up_wack = 1'b1;
            end
            tick();
        end

        for (int h = 0; h <= hold; h++) begin
            check_val("rsp_hs", {u_bus.cmd_ready, u_bus.rsp_valid, u_bus.up_wreq, u_bus.up_rreq}, 4'b0100);
            check_val("rsp_data", {u_bus.rsp_error, u_bus.rsp_rdata}, exp);
            check_val("rsp_bus", {u_bus.up_waddr, u_bus.up_raddr, u_bus.up_wdata}, 60'h0);
            drive_garbage_cmd();
            u_bus.up_wack   = 1'($urandom_range(0, 1));
            u_bus.up_rack   = 1'($urandom_range(0, 1));
            u_bus.up_rdata  = $urandom;
            u_bus.rsp_ready = (h == hold);
            if (h == hold) u_bus.cmd_valid = 1'b0;
            tick();
        end
        drive_idle();
        check_val("after_rsp", {u_bus.cmd_ready, u_bus.rsp_valid, u_bus.rsp_error}, 3'b100);
        if (wr && !exp.error) mem[idx] = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        drive_idle();
        rstn = 1'b0;
        tick();
        tick();
        check_val("rst_hs", {u_bus.rsp_valid, u_bus.up_wreq, u_bus.up_rreq, u_bus.rsp_error}, 4'b0000);
        check_val("rst_data", {u_bus.rsp_rdata, u_bus.up_waddr, u_bus.up_raddr}, 60'h0);
        check_val("rst_wdata", u_bus.up_wdata, 32'h0);
        rstn = 1'b1;
        tick();
        check_val("rst_ready", u_bus.cmd_ready, 1'b1);

        do_cmd(1'b1, 14'h4, 32'hDEADBEEF, 1, 0);
        do_cmd(1'b1, 14'h2, 32'h12345678, 1, 0);
        do_cmd(1'b0, 14'h2, 32'h0, 1, 0);

        do_cmd(1'b0, 14'h7, 32'h0, 0, 0);
        do_cmd(1'b1, 14'h9, 32'hA5A5A5A5, 100, 0);
        for (int i = 0; i < 3; i++) begin
            u_bus.up_wack = 1'b1;
            u_bus.up_rack = 1'($urandom_range(0, 1));
            tick();
            check_val("stray_ack_idle", {u_bus.cmd_ready, u_bus.rsp_valid, u_bus.up_wreq, u_bus.up_rreq}, 4'b1000);
        end
        drive_idle();

        do_cmd(1'b0, 14'h4, 32'h0, 1, 10);
        do_cmd(1'b1, 14'h4, 32'h0BADF00D, 1, 0);
        do_cmd(1'b0, 14'h4, 32'h0, 1, 0);

        do_cmd(1'b0, 14'h2, 32'h0, TO, 0);
        do_cmd(1'b1, 14'h3, 32'h11223344, TO, 1);
        do_cmd(1'b0, 14'h2, 32'h0, TO + 1, 0);

        do_cmd(1'b0, 14'h40, 32'h0, 1, 0);
        do_cmd(1'b0, 14'h3F, 32'h0, 1, 0);
        do_cmd(1'b1, 14'h3FFF, 32'hCAFE0001, 2, 0);

        // Reset pulse while waiting for an ack: the transaction must vanish.
        u_bus.cmd_valid = 1'b1;
        u_bus.cmd_write = 1'b0;
        u_bus.cmd_addr  = 14'h5;
        tick();
        drive_idle();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        check_val("midrst_hs", {u_bus.rsp_valid, u_bus.up_wreq, u_bus.up_rreq, u_bus.rsp_error}, 4'b0000);
        check_val("midrst_bus", {u_bus.up_waddr, u_bus.up_raddr, u_bus.up_wdata}, 60'h0);
        check_val("midrst_rdata", u_bus.rsp_rdata, 32'h0);
        rstn = 1'b1;
        u_bus.up_rack  = 1'b1;
        u_bus.up_rdata = $urandom;
        tick();
        check_val("late_rack", {u_bus.cmd_ready, u_bus.rsp_valid}, 2'b10);
        u_bus.up_rack = 1'b0;
        u_bus.up_wack = 1'b1;
        tick();
        check_val("late_wack", {u_bus.cmd_ready, u_bus.rsp_valid}, 2'b10);
        drive_idle();

        for (int n = 0; n < 40; n++) begin
            do_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
                   int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
